// File: rtl/stage_out_tx_pkg.sv
// Shared types for the stage output transmitter: the result word format
// and the frame FSM state encoding.
package stage_out_tx_pkg;

    // 24-bit significand (hidden bit implied) and 8-bit exponent
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_24_8;

    localparam int unsigned FLOAT_W = $bits(float_24_8);

    typedef enum logic {
        StIdle,
        StSend
    } tx_state_e;

    localparam int unsigned FRAMES_W = 8;

endpackage

// File: rtl/stage_out_fifo.sv
// Word FIFO between the stage datapath and the framer. Full writes are
// dropped unless a pop frees a slot in the same cycle.
module stage_out_fifo
    import stage_out_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  float_24_8        wdata,
    input  logic             pop,
    output float_24_8        rdata,
    output logic [LVL_W-1:0] level,
    output logic             drop
);

    float_24_8        mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;
    logic             is_full;

    assign is_full = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop && (level_q != '0);
    assign do_push = push && (!is_full || do_pop);
    assign drop    = push && !do_push;

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign level = level_q;

endmodule

// File: rtl/stage_out_tx.sv
// Buffers stage results and releases them downstream as whole frames of
// frame_length+1 words, holding each word until it is accepted.
module stage_out_tx
    import stage_out_tx_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned FRAME_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  float_24_8               stage_data,
    input  logic                    stage_data_vld,
    input  logic [FRAME_W-1:0]      frame_length,
    output float_24_8               data_out,
    output logic                    data_out_vld,
    output logic                    data_out_fst,
    input  logic                    data_out_rdy,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    output logic [FRAMES_W-1:0]     frames_sent
);

    tx_state_e             state_q;
    logic [FRAME_W-1:0]    len_q;
    logic [FRAME_W-1:0]    cnt_q;
    logic                  overflow_q;
    logic [FRAMES_W-1:0]   frames_q;
    logic                  pop;
    logic                  drop;
    logic                  frame_ready;
    logic                  last_word;

    stage_out_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (stage_data_vld),
        .wdata (stage_data),
        .pop   (pop),
        .rdata (data_out),
        .level (fifo_level),
        .drop  (drop)
    );

    assign pop         = data_out_vld && data_out_rdy;
    assign frame_ready = 32'(fifo_level) >= (32'(frame_length) + 32'd1);
    assign last_word   = (cnt_q == len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            frames_q   <= '0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    // Only start once the whole frame is buffered so it never stalls on input
                    if (frame_ready) begin
                        state_q <= StSend;
                        len_q   <= frame_length;
                        cnt_q   <= '0;
                    end
                end
                StSend: begin
                    if (pop) begin
                        if (last_word) begin
                            state_q  <= StIdle;
                            cnt_q    <= '0;
                            frames_q <= frames_q + 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign data_out_vld = (state_q == StSend);
    assign data_out_fst = data_out_vld && (cnt_q == '0);
    assign overflow     = overflow_q;
    assign frames_sent  = frames_q;

endmodule

// File: tb/tb_stage_out_tx.sv
// Directed bench for stage_out_tx: framing, backpressure, overflow, full
// push/pop, back-to-back frames and mid-frame reset.
module tb_stage_out_tx;
    import stage_out_tx_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned FRAME_W = 3;

    logic               clk = 1'b0;
    logic               reset;
    float_24_8          stage_data;
    logic               stage_data_vld;
    logic [FRAME_W-1:0] frame_length;
    float_24_8          data_out;
    logic               data_out_vld;
    logic               data_out_fst;
    logic               data_out_rdy;
    logic [3:0]         fifo_level;
    logic               overflow;
    logic [7:0]         frames_sent;
    logic [31:0]        dout;

    int total = 0;
    int bad   = 0;

    assign dout = data_out;

    always #5 clk = ~clk;

    stage_out_tx #(
        .DEPTH   (DEPTH),
        .FRAME_W (FRAME_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stage_data     (stage_data),
        .stage_data_vld (stage_data_vld),
        .frame_length   (frame_length),
        .data_out       (data_out),
        .data_out_vld   (data_out_vld),
        .data_out_fst   (data_out_fst),
        .data_out_rdy   (data_out_rdy),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .frames_sent    (frames_sent)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stage_data     = '0;
        stage_data_vld = 1'b0;
        data_out_rdy   = 1'b0;
        frame_length   = '0;
        reset          = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            stage_data     = float_24_8'(base + 32'(i));
            stage_data_vld = 1'b1;
            cyc();
        end
        stage_data_vld = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stage_data_vld = 1'b0;
        data_out_rdy = 1'b0;
        frame_length = '0;
        stage_data = '0;
        #3;
        total++;
        if (data_out_vld !== 1'b0) begin
            bad++; $display("FAIL reset_vld got=%0b want=0", data_out_vld);
        end
        total++;
        if (data_out_fst !== 1'b0) begin
            bad++; $display("FAIL reset_fst got=%0b want=0", data_out_fst);
        end
        total++;
        if (fifo_level !== 4'd0) begin
            bad++; $display("FAIL reset_level got=%0d want=0", fifo_level);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL reset_overflow got=%0b want=0", overflow);
        end
        total++;
        if (frames_sent !== 8'd0) begin
            bad++; $display("FAIL reset_frames got=%0d want=0", frames_sent);
        end
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        do_reset();
        frame_length = 3'd3;
        data_out_rdy = 1'b1;
        push_words(32'h3F80_0010, 4);
        total++;
        if (data_out_vld !== 1'b0) begin
            bad++; $display("FAIL single_latency got=%0b want=0", data_out_vld);
        end
        cyc();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (data_out_vld !== 1'b1 || dout !== 32'h3F80_0010 + 32'(i) ||
                data_out_fst !== (i == 0)) begin
                bad++;
                $display("FAIL single_word%0d got vld=%0b fst=%0b data=%h want vld=1 fst=%0b data=%h",
                         i, data_out_vld, data_out_fst, dout, (i == 0), 32'h3F80_0010 + 32'(i));
            end
            cyc();
        end
        total++;
        if (data_out_vld !== 1'b0 || frames_sent !== 8'd1 || fifo_level !== 4'd0) begin
            bad++;
            $display("FAIL single_end got vld=%0b frames=%0d level=%0d want 0/1/0",
                     data_out_vld, frames_sent, fifo_level);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        do_reset();
        frame_length = 3'd3;
        data_out_rdy = 1'b0;
        push_words(32'h4000_0020, 4);
        cyc();
        idx = 0;
        for (int k = 0; k < 16 && idx < 4; k++) begin
            total++;
            if (data_out_vld !== 1'b1 || dout !== 32'h4000_0020 + 32'(idx) ||
                data_out_fst !== (idx == 0)) begin
                bad++;
                $display("FAIL bp_cycle%0d got vld=%0b fst=%0b data=%h want vld=1 fst=%0b data=%h",
                         k, data_out_vld, data_out_fst, dout, (idx == 0),
                         32'h4000_0020 + 32'(idx));
            end
            data_out_rdy = (k % 2 == 1);
            if (data_out_rdy) idx++;
            cyc();
        end
        data_out_rdy = 1'b0;
        total++;
        if (data_out_vld !== 1'b0 || frames_sent !== 8'd1 || fifo_level !== 4'd0) begin
            bad++;
            $display("FAIL bp_end got vld=%0b frames=%0d level=%0d want 0/1/0",
                     data_out_vld, frames_sent, fifo_level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        frame_length = 3'd3;
        data_out_rdy = 1'b0;
        push_words(32'h4100_0000, 8);
        total++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_full got level=%0d ovf=%0b want 8/0", fifo_level, overflow);
        end
        push_words(32'hDEAD_0009, 1);
        total++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drop got level=%0d ovf=%0b want 8/1", fifo_level, overflow);
        end
        total++;
        if (data_out_vld !== 1'b1 || dout !== 32'h4100_0000) begin
            bad++;
            $display("FAIL ovf_head got vld=%0b data=%h want 1/41000000", data_out_vld, dout);
        end
        cyc();
        cyc();
        cyc();
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_sticky got=%0b want=1", overflow);
        end
        // Drain: two 4-word frames empty the FIFO only if the 9th word was dropped
        data_out_rdy = 1'b1;
        for (int k = 0; k < 12; k++) cyc();
        total++;
        if (fifo_level !== 4'd0 || frames_sent !== 8'd2 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drain got level=%0d frames=%0d ovf=%0b want 0/2/1",
                     fifo_level, frames_sent, overflow);
        end
        do_reset();
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_clear got=%0b want=0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        frame_length = 3'd7;
        data_out_rdy = 1'b0;
        push_words(32'h4200_0000, 8);
        total++;
        if (fifo_level !== 4'd8 || data_out_vld !== 1'b0) begin
            bad++;
            $display("FAIL fpp_fill got level=%0d vld=%0b want 8/0", fifo_level, data_out_vld);
        end
        cyc();
        total++;
        if (data_out_vld !== 1'b1 || dout !== 32'h4200_0000 || data_out_fst !== 1'b1) begin
            bad++;
            $display("FAIL fpp_start got vld=%0b fst=%0b data=%h want 1/1/42000000",
                     data_out_vld, data_out_fst, dout);
        end
        data_out_rdy   = 1'b1;
        stage_data     = float_24_8'(32'h4200_00AA);
        stage_data_vld = 1'b1;
        cyc();
        stage_data_vld = 1'b0;
        total++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL fpp_both got level=%0d ovf=%0b want 8/0", fifo_level, overflow);
        end
        for (int i = 1; i < 8; i++) begin
            total++;
            if (data_out_vld !== 1'b1 || dout !== 32'h4200_0000 + 32'(i) ||
                data_out_fst !== 1'b0) begin
                bad++;
                $display("FAIL fpp_word%0d got vld=%0b fst=%0b data=%h want vld=1 fst=0 data=%h",
                         i, data_out_vld, data_out_fst, dout, 32'h4200_0000 + 32'(i));
            end
            cyc();
        end
        total++;
        if (data_out_vld !== 1'b0 || frames_sent !== 8'd1 || fifo_level !== 4'd1) begin
            bad++;
            $display("FAIL fpp_end got vld=%0b frames=%0d level=%0d want 0/1/1",
                     data_out_vld, frames_sent, fifo_level);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_vld;
        logic [10:0] exp_fst;
        int          widx;
        do_reset();
        frame_length = 3'd1;
        data_out_rdy = 1'b1;
        exp_vld = 11'b01101101100;
        exp_fst = 11'b00100100100;
        widx = 0;
        for (int k = 0; k < 11; k++) begin
            stage_data     = float_24_8'(32'h4300_0000 + 32'(k));
            stage_data_vld = (k < 6);
            cyc();
            total++;
            if (data_out_vld !== exp_vld[k] || data_out_fst !== exp_fst[k] ||
                (exp_vld[k] && dout !== 32'h4300_0000 + 32'(widx))) begin
                bad++;
                $display("FAIL b2b_cycle%0d got vld=%0b fst=%0b data=%h want vld=%0b fst=%0b data=%h",
                         k, data_out_vld, data_out_fst, dout, exp_vld[k], exp_fst[k],
                         32'h4300_0000 + 32'(widx));
            end
            if (exp_vld[k]) widx++;
        end
        stage_data_vld = 1'b0;
        total++;
        if (frames_sent !== 8'd3 || fifo_level !== 4'd0) begin
            bad++;
            $display("FAIL b2b_end got frames=%0d level=%0d want 3/0", frames_sent, fifo_level);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        frame_length = 3'd3;
        data_out_rdy = 1'b1;
        push_words(32'h4400_0000, 4);
        cyc();
        total++;
        if (data_out_vld !== 1'b1 || dout !== 32'h4400_0000) begin
            bad++;
            $display("FAIL rmf_first got vld=%0b data=%h want 1/44000000", data_out_vld, dout);
        end
        cyc();
        reset = 1'b1;
        #1;
        total++;
        if (data_out_vld !== 1'b0 || data_out_fst !== 1'b0 || fifo_level !== 4'd0) begin
            bad++;
            $display("FAIL rmf_async got vld=%0b fst=%0b level=%0d want 0/0/0",
                     data_out_vld, data_out_fst, fifo_level);
        end
        cyc();
        reset = 1'b0;
        push_words(32'h4500_0000, 4);
        total++;
        if (data_out_vld !== 1'b0) begin
            bad++; $display("FAIL rmf_gap got=%0b want=0", data_out_vld);
        end
        cyc();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (data_out_vld !== 1'b1 || dout !== 32'h4500_0000 + 32'(i) ||
                data_out_fst !== (i == 0)) begin
                bad++;
                $display("FAIL rmf_word%0d got vld=%0b fst=%0b data=%h want vld=1 fst=%0b data=%h",
                         i, data_out_vld, data_out_fst, dout, (i == 0), 32'h4500_0000 + 32'(i));
            end
            cyc();
        end
        total++;
        if (frames_sent !== 8'd1 || fifo_level !== 4'd0) begin
            bad++;
            $display("FAIL rmf_end got frames=%0d level=%0d want 1/0", frames_sent, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_out_tx.md
STAGE_OUT_TX -- requirements
Module: stage_out_tx

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, 2..16).
REQ-002 Parameter FRAME_W, default 3, width of frame_length.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stage_data  input  float_24_8  result word from stage datapath; no backpressure.
REQ-006 stage_data_vld  input  1  stage_data valid this cycle.
REQ-007 frame_length  input  FRAME_W  words per frame minus one.
REQ-008 data_out  output  float_24_8  frame word to downstream stage input.
REQ-009 data_out_vld  output  1  data_out valid.
REQ-010 data_out_fst  output  1  first word of frame.
REQ-011 data_out_rdy  input  1  downstream accepts word.
REQ-012 fifo_level  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 overflow  output  1  sticky: a stage word was dropped.
REQ-014 frames_sent  output  8  completed frame count.

Function
REQ-015 FIFO SHALL write stage_data when stage_data_vld and (level<DEPTH or a pop occurs the same cycle).
REQ-016 Write with level==DEPTH and no same-cycle pop SHALL drop the word, leave FIFO unchanged, set overflow.
REQ-017 Pop SHALL occur iff data_out_vld & data_out_rdy; simultaneous push+pop keeps level unchanged.
REQ-018 data_out SHALL be the FIFO head combinationally; unspecified when data_out_vld=0.
REQ-019 FSM states: IDLE, SEND; reset state IDLE.
REQ-020 IDLE->SEND when registered level >= frame_length+1 (full frame buffered); frame_length latched into len_q on that edge.
REQ-021 data_out_vld SHALL equal (state==SEND); first vld cycle is the cycle after the enabling edge.
REQ-022 Word counter (FRAME_W bits) cleared entering SEND, +1 on each pop.
REQ-023 data_out_fst SHALL be data_out_vld & (word counter==0).
REQ-024 Pop with counter==len_q SHALL return to IDLE, clear counter, increment frames_sent (mod 256).
REQ-025 data_out_vld held with data_out stable while data_out_rdy=0 (no withdrawal mid-frame).
REQ-026 frame_length changes during SEND SHALL not affect the current frame.
REQ-027 Back-to-back frames SHALL have exactly one IDLE cycle between last word and next fst.
REQ-028 Pointers wrap modulo DEPTH; level never exceeds DEPTH or underflows.

Reset
REQ-029 Reset SHALL clear pointers, level, counter, frames_sent, overflow, state=IDLE asynchronously.
REQ-030 Outputs under reset: data_out_vld=0, data_out_fst=0, fifo_level=0, overflow=0, frames_sent=0.
REQ-031 Reset mid-frame SHALL drop vld immediately and discard buffered words; no partial frame resumes.

Structure
REQ-032 float_24_8 and the FSM state enum SHALL come from the shared types package.
REQ-033 FIFO storage/pointers SHALL be one sub-module, stage_out_fifo; FSM and counters in top.

Verification
REQ-034 frame_length=3, push 4 words A..D, rdy=1 -> vld 1 cycle after D's write edge, A(fst) B C D on consecutive cycles, frames_sent=1, level=0.
REQ-035 frame_length=3, rdy toggled 1/0 -> each word held until accepted, fst only on A, 4 pops total.
REQ-036 DEPTH=8, rdy=0, push 9 words -> level=8, 9th dropped, overflow=1 until reset.
REQ-037 level=8, pop and push same cycle -> word accepted, level stays 8, overflow stays 0.
REQ-038 frame_length=1, 6 words pushed continuously, rdy=1 -> 3 frames, one idle cycle between each, frames_sent=3.
REQ-039 Reset asserted after 2nd word of 4-word frame -> vld=0 same cycle, level=0; after release, new 4 words yield fresh frame with fst on first.
